// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master arbiter in front of a single-port 32-bit byte-masked word memory
//   with a 1-cycle registered read. Port 0 is the CPU side, port 1 the loader /
//   debug side. Each access takes exactly three cycles: IDLE (grant + latch),
//   ISSUE (drive memory), RESP (ack + read data back to the granted master).
//   Accesses with addr >= MEM_BYTES are trapped: memory is never strobed and
//   the master gets ack with err=1 and rdata=0.
//
// Parameters
//   MEM_BYTES   decoded memory size in bytes (default 1024 = 256 words)
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   mN_req/addr/wdata/wmask      master N request (wmask 4'b0000 = read)
//   mN_ack/rdata/err             master N one-cycle completion, read data, range error
//   mem_addr/rstrb/wdata/wmask   memory command (strobes only in ISSUE)
//   mem_rdata                    memory read data, valid the cycle after mem_rstrb
//   dbg_state                    current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//
// Build option
//   MEM_ARB_PRIO_EN  defined: fixed priority, port 0 wins every tie (port 1 may
//                    starve). Undefined: round-robin on ties.
//
// Handshake: a master raises req with addr/wdata/wmask and holds them stable
// until it samples ack=1; at that same edge it drops req or presents the next
// transaction. The arbiter only looks at req in IDLE, so req seen in the IDLE
// after RESP is always a new access.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        grant;      // 0 = port 0 owns the current access, 1 = port 1
  logic        pick;       // arbitration winner this cycle
  logic        any_req;
  logic        take;       // accept a new access this cycle
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;
  logic        lat_inr;    // latched in-range flag
  logic [31:0] sel_addr;
  logic [31:0] resp_rdata;

  assign any_req  = m0_req | m1_req;
  assign take     = (state == S_IDLE) && any_req;
  assign sel_addr = pick ? m1_addr : m0_addr;

`ifdef MEM_ARB_PRIO_EN
  // Port 0 wins whenever it requests.
  assign pick = ~m0_req;
`else
  // Round-robin: on a tie the port not granted last time wins. Reset value 1
  // makes port 0 win the first tie.
  logic last_grant;

  assign pick = (m0_req && m1_req) ? ~last_grant : ~m0_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= pick;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      grant     <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wmask <= 4'h0;
      lat_inr   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        grant     <= pick;
        lat_addr  <= sel_addr;
        lat_wdata <= pick ? m1_wdata : m0_wdata;
        lat_wmask <= pick ? m1_wmask : m0_wmask;
        lat_inr   <= (sel_addr < MEM_LIMIT);
      end
    end
  end

  // Strobes and acks decode straight from state, so an asynchronous reset
  // removes them in the same cycle and an interrupted write is never committed.
  always_comb begin
    state_nx   = state;
    mem_rstrb  = 1'b0;
    mem_wmask  = 4'h0;
    resp_rdata = 32'h0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_rdata   = 32'h0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_rdata   = 32'h0;
    case (state)
      S_IDLE: begin
        if (any_req) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (lat_inr) begin
          mem_rstrb = (lat_wmask == 4'h0);
          mem_wmask = lat_wmask;
        end
        state_nx = S_RESP;
      end
      S_RESP: begin
        if (lat_inr && (lat_wmask == 4'h0)) resp_rdata = mem_rdata;
        if (grant) begin
          m1_ack   = 1'b1;
          m1_err   = ~lat_inr;
          m1_rdata = resp_rdata;
        end else begin
          m0_ack   = 1'b1;
          m0_err   = ~lat_inr;
          m0_rdata = resp_rdata;
        end
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter. A behavioural memory sits on the mem_* side. The
//   reference model is a shadow copy of memory plus a cycle-number schedule:
//   a grant at edge c drives memory in the window after c, commits a write at
//   edge c+1, acks in the window after c+1 and lets the next grant happen at
//   edge c+3. Expected read data is taken from the shadow at grant time and
//   queued until the ack.
module tb_mem_arbiter;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int TXN_BUDGET = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_state;

  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wmask [2];
  logic [1:0]  ack_v, err_v;
  logic [31:0] rd_v  [2];

  assign m0_req = req[0];   assign m1_req = req[1];
  assign m0_addr = addr[0]; assign m1_addr = addr[1];
  assign m0_wdata = wdata[0]; assign m1_wdata = wdata[1];
  assign m0_wmask = wmask[0]; assign m1_wmask = wmask[1];
  assign ack_v = {m1_ack, m0_ack};
  assign err_v = {m1_err, m0_err};
  assign rd_v[0] = m0_rdata;
  assign rd_v[1] = m1_rdata;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory (environment) ----------------
  logic        mem_load = 1'b1;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow [256];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          free_at = 1 << 30;
  int          grant_cyc = -100;
  int          gport = 0;
  bit          last_g = 1'b1;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0;
  logic [3:0]  t_mask = 4'h0;
  bit          t_inr = 1'b0;

  // ---------------- master side state ----------------
  bit          seen_ack [2];
  logic [31:0] seen_rd  [2];
  logic        seen_err [2];
  int          rate     [2];

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    req[p] = 1'b1; addr[p] = a; wdata[p] = d; wmask[p] = m;
  endtask

  task automatic new_rand(input int p);
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(9);
    if (k < 7)       a = 32'($urandom_range(MEM_BYTES - 1));
    else if (k == 7) a = 32'h3FC + 32'($urandom_range(3));
    else if (k == 8) a = MEM_BYTES + 32'($urandom_range(3));
    else             a = $urandom | 32'h8000_0000;
    set_req(p, a, $urandom, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15)));
  endtask

  // One clock: advance the model, compare every DUT output, then act as masters.
  task automatic step();
    bit issue, resp, a;
    logic [31:0] cur_exp;
    @(posedge clk);
    #1;
    cyc++;
    if (resetn) begin
      if (cyc == grant_cyc + 1 && t_inr && t_mask != 4'h0)
        for (int b = 0; b < 4; b++)
          if (t_mask[b]) shadow[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];
      if (cyc >= free_at && (req[0] || req[1])) begin
        if (req[0] && req[1]) begin
`ifdef MEM_ARB_PRIO_EN
          gport = 0;
`else
          gport = last_g ? 0 : 1;
`endif
        end else begin
          gport = req[0] ? 0 : 1;
        end
        last_g    = (gport == 1);
        grant_cyc = cyc;
        free_at   = cyc + 3;
        t_addr    = addr[gport];
        t_wdata   = wdata[gport];
        t_mask    = wmask[gport];
        t_inr     = (t_addr < MEM_BYTES);
        exp_q.push_back((t_inr && t_mask == 4'h0) ? shadow[t_addr[9:2]] : 32'h0);
      end
    end
    issue = resetn && (cyc == grant_cyc);
    resp  = resetn && (cyc == grant_cyc + 1);
    cur_exp = 32'h0;
    if (resp && exp_q.size() > 0) cur_exp = exp_q.pop_front();
    check("mem_rstrb", 32'(mem_rstrb), 32'(issue && t_inr && t_mask == 4'h0));
    check("mem_wmask", 32'(mem_wmask), (issue && t_inr) ? 32'(t_mask) : 32'h0);
    if (issue) begin
      check("mem_addr", mem_addr, t_addr);
      check("mem_wdata", mem_wdata, t_wdata);
    end
    for (int p = 0; p < 2; p++) begin
      a = resp && (gport == p);
      check($sformatf("m%0d_ack", p), 32'(ack_v[p]), 32'(a));
      check($sformatf("m%0d_err", p), 32'(err_v[p]), 32'(a && !t_inr));
      check($sformatf("m%0d_rdata", p), rd_v[p], a ? cur_exp : 32'h0);
    end
    for (int p = 0; p < 2; p++) begin
      if (ack_v[p]) begin
        seen_ack[p] = 1'b1;
        seen_rd[p]  = rd_v[p];
        seen_err[p] = err_v[p];
        req[p]      = 1'b0;
      end
      if (!req[p] && rate[p] > 0 && int'($urandom_range(99)) < rate[p]) new_rand(p);
    end
  endtask

  // Directed access: present it, wait (bounded) for its ack, report latency.
  task automatic txn(input int p, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output int lat);
    set_req(p, a, d, m);
    seen_ack[p] = 1'b0;
    lat = 0;
    while (lat < TXN_BUDGET && !seen_ack[p]) begin
      step();
      lat++;
    end
    check($sformatf("m%0d_txn_done", p), 32'(seen_ack[p]), 32'd1);
  endtask

  initial begin
    int lat;
    int guard;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0; wmask[p] = 4'h0;
      rate[p] = 0; seen_ack[p] = 1'b0; seen_rd[p] = 32'h0; seen_err[p] = 1'b0;
    end
    for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE0000 | 32'(i);

    // Reset state
    #2;
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_rstrb", 32'(mem_rstrb), 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    step();
    step();
    mem_load = 1'b0;
    resetn = 1'b1;
    free_at = cyc + 1;

    // Full-word write then read-back on port 0; ack two edges after request
    // from idle, then three cycles per back-to-back access.
    txn(0, 32'h190, 32'h04030201, 4'hF, lat);
    check("t1_write_latency", 32'(lat), 32'd2);
    txn(0, 32'h190, 32'h0, 4'h0, lat);
    check("t1_read_latency", 32'(lat), 32'd3);
    check("t1_rdata", seen_rd[0], 32'h04030201);
    check("t1_err", 32'(seen_err[0]), 32'h0);

    // Single byte-lane write on port 1
    txn(1, 32'h321, 32'h0000AB00, 4'b0010, lat);
    txn(1, 32'h320, 32'h0, 4'h0, lat);
    check("t2_rdata", seen_rd[1], 32'hC0DEABC8);

    // Range boundary
    txn(0, 32'h400, 32'h0, 4'h0, lat);
    check("t4_oor_err", 32'(seen_err[0]), 32'h1);
    check("t4_oor_rdata", seen_rd[0], 32'h0);
    txn(0, 32'h3FC, 32'h0, 4'h0, lat);
    check("t4_last_err", 32'(seen_err[0]), 32'h0);
    check("t4_last_rdata", seen_rd[0], 32'hC0DE00FF);
    txn(1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, lat);
    check("t4_oor_write_err", 32'(seen_err[1]), 32'h1);

    // Reset during ISSUE of a write to 0x10
    repeat (3) step();
    set_req(0, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    resetn = 1'b0;
    #1;
    check("t5_wmask_drop", 32'(mem_wmask), 32'h0);
    check("t5_rstrb_drop", 32'(mem_rstrb), 32'h0);
    check("t5_no_ack", 32'(m0_ack), 32'h0);
    req[0] = 1'b0;
    grant_cyc = -100;
    free_at = 1 << 30;
    last_g = 1'b1;
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    free_at = cyc + 1;
    txn(0, 32'h10, 32'h0, 4'h0, lat);
    check("t5_mem4_unchanged", seen_rd[0], 32'hC0DE0004);

    // Both masters requesting continuously (arbitration pattern + spacing)
    repeat (3) step();
    rate[0] = 100;
    rate[1] = 100;
    repeat (60) step();

    // Random traffic
    rate[0] = 0;
    rate[1] = 0;
    guard = 0;
    while ((req[0] || req[1]) && guard < 60) begin
      step();
      guard++;
    end
    rate[0] = 35 + int'($urandom_range(40));
    rate[1] = 35 + int'($urandom_range(40));
    repeat (500) step();

    // Drain
    rate[0] = 0;
    rate[1] = 0;
    guard = 0;
    while ((req[0] || req[1]) && guard < 60) begin
      step();
      guard++;
    end
    check("drain_done", 32'(req[0] || req[1]), 32'h0);
    repeat (4) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
